// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Result is {remainder, quotient}; busy stalls the front of the pipe.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
  logic             qneg_q, rneg_q;

  logic             a_neg, b_neg, last;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx, quot_nx;
  logic [WIDTH-1:0] rem_fix, quot_fix;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // Upper WIDTH+1 bits of the shifted pair minus the divisor
  assign trial   = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
  assign rem_nx  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]}
                                : trial[WIDTH-1:0];
  assign quot_nx = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
  assign rem_fix  = rneg_q ? -rem_nx : rem_nx;
  assign quot_fix = qneg_q ? -quot_nx : quot_nx;
  assign last     = (cnt_q == CW'(WIDTH - 1));

  assign ready = (state_q == END);
  assign busy  = start & ~ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !annul)
          state_d = (b == '0) ? DIVZERO : ON;
      end
      DIVZERO: state_d = annul ? IDLE : END;
      ON: begin
        if (annul)     state_d = IDLE;
        else if (last) state_d = END;
      end
      END: begin
        if (annul || !start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      result <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !annul) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quot_q <= abs_a;
            dvs_q  <= abs_b;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
          end
        end
        ON: begin
          if (!annul) begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q + 1'b1;
            if (last) result <= {rem_fix, quot_fix};
          end
        end
        DIVZERO: begin
          if (!annul) result <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
